// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the conv input feeder.
//   - default parameter widths for the feeder and its address generator
//   - MAX_WIDTH: longest row (padding included) the downstream row buffers hold
//   - state_e: feeder FSM encoding
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CH_NUM_DEF     = 18;
  localparam int DIM_WIDTH_DEF  = 9;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int MAX_WIDTH      = 320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/conv_feed_addr_gen.sv
// conv_feed_addr_gen: raster walker over the effective (possibly padded)
// feature map.
//   clk, rstn     clock, async active-low reset
//   init_i        reload counters and address from the latched config
//   adv_i         one pixel was issued this cycle, step to the next one
//   eff_w_i/h_i   effective width/height (padding included)
//   pad_i         1-pixel zero border active
//   base_addr_i   address of unpadded pixel (0,0)
//   border_o      current pixel lies on the zero border
//   last_o        current pixel is the final one of the layer
//   addr_o        memory address of the current interior pixel
module conv_feed_addr_gen
  import conv_pkg::*;
#(
  parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init_i,
  input  logic                  adv_i,
  input  logic [DIM_WIDTH:0]    eff_w_i,
  input  logic [DIM_WIDTH:0]    eff_h_i,
  input  logic                  pad_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  border_o,
  output logic                  last_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam int EW = DIM_WIDTH + 1;

  logic [EW-1:0]         row_q, col_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  col_end, row_end;

  assign col_end  = (col_q == eff_w_i - EW'(1));
  assign row_end  = (row_q == eff_h_i - EW'(1));
  assign border_o = pad_i & ((row_q == '0) | row_end | (col_q == '0) | col_end);
  assign last_o   = row_end & col_end;
  assign addr_o   = addr_q;

  // Interior pixels are visited in the same raster order they are stored,
  // so the address simply steps by one per interior pixel; border pixels
  // leave it untouched. Overflow wraps modulo 2^ADDR_WIDTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else if (init_i) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= base_addr_i;
    end else if (adv_i) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_q + EW'(1);
      end else begin
        col_q <= col_q + EW'(1);
      end
      if (!border_o) addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_in_feeder.sv
// conv_in_feeder: streams one feature-map layer from feature memory to the
// preprocess stage, one pixel word per cycle, inserting a zero border in
// depthwise mode when requested.
//   clk, rstn                 clock, async active-low reset
//   start                     layer start pulse (ignored unless idle)
//   img_width/img_height      unpadded dims; base_addr address of pixel (0,0)
//   pad_en, pw_cfg            zero border (DW only); 1 = pointwise layer
//   stall                     downstream hold; stops issue the same cycle
//   rd_en/rd_addr/rd_data     feature memory port, 1-cycle read latency
//   data_out/valid_out        pixel word, 2 cycles after issue
//   buff_len_ctrl/_rst        row-buffer length and one-cycle reset pulse
//   PW_mode                   mode for the preprocess stage
//   busy, done, cfg_err       status
module conv_in_feeder
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CH_NUM     = CH_NUM_DEF,
  parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MAX_WIDTH  = conv_pkg::MAX_WIDTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [DIM_WIDTH-1:0]         img_width,
  input  logic [DIM_WIDTH-1:0]         img_height,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic                         pad_en,
  input  logic                         pw_cfg,
  input  logic                         stall,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [CH_NUM*DATA_WIDTH-1:0] rd_data,
  output logic [CH_NUM*DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  output logic [DIM_WIDTH-1:0]         buff_len_ctrl,
  output logic                         buff_len_rst,
  output logic                         PW_mode,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);

  // Effective dims need one extra bit: a padded height can exceed 2^DIM_WIDTH-1.
  localparam int EW = DIM_WIDTH + 1;
  localparam int WW = CH_NUM * DATA_WIDTH;

  state_e state_q, state_d;

  logic                  pad_in, cfg_ok, accept, issue;
  logic [EW-1:0]         eff_w_in, eff_h_in;
  logic [EW-1:0]         eff_w_q, eff_h_q;
  logic                  pad_q, pw_mode_q, drain_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DIM_WIDTH-1:0]  buff_len_q;
  logic                  border, last;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [2:1]            vld_pipe, bord_pipe;
  logic [WW-1:0]         data_q;

  // ---------------------------------------------------------------------------
  // Config check on the incoming start
  // ---------------------------------------------------------------------------
  assign pad_in   = pad_en & ~pw_cfg;
  assign eff_w_in = {1'b0, img_width}  + {{(EW-2){1'b0}}, pad_in, 1'b0};
  assign eff_h_in = {1'b0, img_height} + {{(EW-2){1'b0}}, pad_in, 1'b0};
  assign cfg_ok   = (img_width != '0) && (img_height != '0) &&
                    (eff_w_in <= EW'(MAX_WIDTH)) &&
                    (pw_cfg || ((eff_w_in >= EW'(3)) && (eff_h_in >= EW'(3))));
  assign accept   = (state_q == ST_IDLE) && start && cfg_ok;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start && cfg_ok) state_d = ST_CFG;
      ST_CFG:    state_d = ST_STREAM;
      ST_STREAM: if (issue && last) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_q) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue        = (state_q == ST_STREAM) && !stall;
    busy         = (state_q == ST_CFG) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    buff_len_rst = (state_q == ST_CFG);
    done         = (state_q == ST_DONE);
    cfg_err      = (state_q == ST_IDLE) && start && !cfg_ok;
  end

  // Two DRAIN cycles cover the words still in the read/output pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drain_q <= 1'b0;
    else       drain_q <= (state_q == ST_DRAIN) && !drain_q;
  end

  // ---------------------------------------------------------------------------
  // Latched layer config; PW_mode and buff_len_ctrl hold until the next layer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eff_w_q    <= '0;
      eff_h_q    <= '0;
      pad_q      <= 1'b0;
      base_q     <= '0;
      pw_mode_q  <= 1'b0;
      buff_len_q <= '0;
    end else if (accept) begin
      eff_w_q    <= eff_w_in;
      eff_h_q    <= eff_h_in;
      pad_q      <= pad_in;
      base_q     <= base_addr;
      pw_mode_q  <= pw_cfg;
      buff_len_q <= pw_cfg ? '0 : eff_w_in[DIM_WIDTH-1:0] - DIM_WIDTH'(2);
    end
  end

  assign PW_mode       = pw_mode_q;
  assign buff_len_ctrl = buff_len_q;

  // ---------------------------------------------------------------------------
  // Address generation
  // ---------------------------------------------------------------------------
  conv_feed_addr_gen #(
    .DIM_WIDTH  (DIM_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rstn        (rstn),
    .init_i      (state_q == ST_CFG),
    .adv_i       (issue),
    .eff_w_i     (eff_w_q),
    .eff_h_i     (eff_h_q),
    .pad_i       (pad_q),
    .base_addr_i (base_q),
    .border_o    (border),
    .last_o      (last),
    .addr_o      (gen_addr)
  );

  assign rd_en   = issue & ~border;
  assign rd_addr = rd_en ? gen_addr : '0;

  // ---------------------------------------------------------------------------
  // Output pipeline: stage 1 waits for memory data, stage 2 is the output
  // register. Border pixels ride along with their flag and become zero words.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe  <= '0;
      bord_pipe <= '0;
      data_q    <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[1], issue};
      bord_pipe <= {bord_pipe[1], issue & border};
      data_q    <= (vld_pipe[1] && !bord_pipe[1]) ? rd_data : '0;
    end
  end

  assign valid_out = vld_pipe[2];
  assign data_out  = data_q;

endmodule

// File: tb/tb_conv_in_feeder.sv
module tb_conv_in_feeder;
  localparam int DW = 8, CH = 18, DIMW = 9, AW = 16, MAXW = 320;
  localparam int WW = DW * CH;

  logic            clk = 1'b0, rstn = 1'b1, start = 1'b0;
  logic            pad_en = 1'b0, pw_cfg = 1'b0, stall = 1'b0;
  logic [DIMW-1:0] img_width = '0, img_height = '0;
  logic [AW-1:0]   base_addr = '0;
  logic            rd_en, valid_out, buff_len_rst, PW_mode, busy, done, cfg_err;
  logic [AW-1:0]   rd_addr;
  logic [WW-1:0]   rd_data = '0, data_out;
  logic [DIMW-1:0] buff_len_ctrl;

  conv_in_feeder #(
    .DATA_WIDTH(DW), .CH_NUM(CH), .DIM_WIDTH(DIMW), .ADDR_WIDTH(AW), .MAX_WIDTH(MAXW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .img_width(img_width), .img_height(img_height),
    .base_addr(base_addr), .pad_en(pad_en), .pw_cfg(pw_cfg), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out),
    .valid_out(valid_out), .buff_len_ctrl(buff_len_ctrl), .buff_len_rst(buff_len_rst),
    .PW_mode(PW_mode), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory content is a function of the address; non-read cycles return junk
  // so a border word that is not zeroed shows up.
  function automatic logic [WW-1:0] pat(input logic [AW-1:0] a);
    logic [WW-1:0] w;
    for (int i = 0; i < CH; i++)
      w[i*8 +: 8] = (i % 2 == 0) ? a[7:0] + 8'(i) : a[15:8] + 8'(i);
    return w;
  endfunction

  always @(posedge clk) rd_data <= rd_en ? pat(rd_addr) : {CH{8'hEE}};

  int n_checks = 0, n_fail = 0;
  int n_valid = 0, n_rd = 0, n_blr = 0, n_done = 0, n_err = 0, n_busy = 0, n_stall_valid = 0;
  int last_valid_cyc = 0, done_cyc = 0;
  bit stall_win = 1'b0;
  logic [WW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  function automatic void chkw(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reads or presents a word.
  always @(negedge clk) begin
    if (rstn) begin
      if (busy)         n_busy++;
      if (cfg_err)      n_err++;
      if (buff_len_rst) n_blr++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (rd_en) begin
        n_rd++;
        if (addr_q.size() == 0) chk("rd_unexpected", int'(rd_en), 0);
        else chk("rd_addr", int'(rd_addr), int'(addr_q.pop_front()));
      end
      if (valid_out) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (stall_win) n_stall_valid++;
        if (exp_q.size() == 0) chk("valid_unexpected", int'(valid_out), 0);
        else chkw("data_out", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_valid_out"}, int'(valid_out), 0);
    chk({tag, "_buff_len_rst"}, int'(buff_len_rst), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_PW_mode"}, int'(PW_mode), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_buff_len_ctrl"}, int'(buff_len_ctrl), 0);
    chkw({tag, "_data_out"}, data_out, '0);
  endtask

  // Pushes the expected raster stream; returns the number of memory reads.
  task automatic push_exp(input int w, input int h, input bit pad, input bit pw,
                          input logic [AW-1:0] base, output int nrd);
    int ew, eh;
    bit pe;
    pe = pad && !pw;
    ew = w + (pe ? 2 : 0);
    eh = h + (pe ? 2 : 0);
    nrd = 0;
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++)
        if (pe && (r == 0 || r == eh - 1 || c == 0 || c == ew - 1)) exp_q.push_back('0);
        else begin
          addr_q.push_back(AW'(int'(base) + nrd));
          exp_q.push_back(pat(AW'(int'(base) + nrd)));
          nrd++;
        end
  endtask

  task automatic pulse_start(input int w, input int h, input bit pad, input bit pw,
                             input logic [AW-1:0] base);
    img_width = DIMW'(w); img_height = DIMW'(h); pad_en = pad; pw_cfg = pw; base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_layer(input string nm, input int w, input int h, input bit pad, input bit pw,
                           input logic [AW-1:0] base, input int stall_at, input int stall_len,
                           input bit poke);
    int ew, eh, nrd, v0, r0, b0, d0, e0, s0;
    bit got;
    ew = w + ((pad && !pw) ? 2 : 0);
    eh = h + ((pad && !pw) ? 2 : 0);
    v0 = n_valid; r0 = n_rd; b0 = n_blr; d0 = n_done; e0 = n_err; s0 = n_stall_valid;
    push_exp(w, h, pad, pw, base, nrd);
    pulse_start(w, h, pad, pw, base);
    if (stall_len > 0) begin
      repeat (stall_at) tick();
      stall = 1'b1; stall_win = 1'b1;
      repeat (stall_len) tick();
      stall = 1'b0; stall_win = 1'b0;
    end
    if (poke) begin
      repeat (4) tick();
      pulse_start(5, 5, 1'b1, 1'b0, 16'h1234);
    end
    got = 1'b0;
    for (int i = 0; i < ew * eh + 50; i++) begin
      if (n_done != d0) begin got = 1'b1; break; end
      tick();
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    repeat (3) tick();
    chk({nm, "_valid_count"}, n_valid - v0, ew * eh);
    chk({nm, "_read_count"}, n_rd - r0, nrd);
    chk({nm, "_buff_len_rst_count"}, n_blr - b0, 1);
    chk({nm, "_done_count"}, n_done - d0, 1);
    chk({nm, "_cfg_err_count"}, n_err - e0, 0);
    chk({nm, "_exp_left"}, exp_q.size(), 0);
    chk({nm, "_addr_left"}, addr_q.size(), 0);
    chk({nm, "_done_after_last_valid"}, done_cyc - last_valid_cyc, 1);
    chk({nm, "_buff_len_ctrl"}, int'(buff_len_ctrl), pw ? 0 : ew - 2);
    chk({nm, "_PW_mode"}, int'(PW_mode), int'(pw));
    chk({nm, "_busy_after"}, int'(busy), 0);
    if (stall_len > 0) chk({nm, "_valid_in_stall_le2"}, int'((n_stall_valid - s0) <= 2), 1);
    exp_q.delete(); addr_q.delete();
  endtask

  task automatic expect_reject(input string nm, input int w, input int h, input bit pad, input bit pw);
    int e0, b0, bl0;
    e0 = n_err; b0 = n_busy; bl0 = n_blr;
    pulse_start(w, h, pad, pw, 16'h0000);
    repeat (5) tick();
    chk({nm, "_cfg_err_pulses"}, n_err - e0, 1);
    chk({nm, "_busy_cycles"}, n_busy - b0, 0);
    chk({nm, "_buff_len_rst"}, n_blr - bl0, 0);
  endtask

  initial begin
    int nrd, v0;
    #2 rstn = 1'b0;
    repeat (2) tick();
    check_idle_outputs("reset");
    rstn = 1'b1;
    repeat (2) tick();

    run_layer("dw_pad_4x3", 4, 3, 1'b1, 1'b0, 16'h0040, 0, 0, 1'b0);
    run_layer("pw_5x2", 5, 2, 1'b1, 1'b1, 16'h0300, 0, 0, 1'b0);
    run_layer("dw_pad_318x3", 318, 3, 1'b1, 1'b0, 16'h1000, 0, 0, 1'b0);
    expect_reject("rej_w319_pad", 319, 3, 1'b1, 1'b0);
    expect_reject("rej_zero_h", 4, 0, 1'b0, 1'b1);
    expect_reject("rej_dw_w2", 2, 3, 1'b0, 1'b0);
    run_layer("dw_stall", 4, 3, 1'b0, 1'b0, 16'h0500, 3, 5, 1'b0);

    // Reset in the middle of a layer, then a clean 3x3 layer.
    push_exp(8, 8, 1'b0, 1'b0, 16'h0100, nrd);
    pulse_start(8, 8, 1'b0, 1'b0, 16'h0100);
    repeat (8) tick();
    rstn = 1'b0;
    exp_q.delete(); addr_q.delete();
    tick();
    check_idle_outputs("midrst");
    tick();
    rstn = 1'b1;
    v0 = n_valid;
    repeat (6) tick();
    chk("post_reset_no_valid", n_valid - v0, 0);
    run_layer("after_rst_3x3", 3, 3, 1'b0, 1'b0, 16'h0200, 0, 0, 1'b0);

    // Start while busy is ignored; address wraps past 0xFFFF.
    run_layer("busy_start_wrap", 4, 3, 1'b0, 1'b0, 16'hFFFE, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
